// File: rtl/imem_responder.sv
// imem_responder
//   Serves instruction-cache read requests from a shared RAM port. A request
//   is accepted in IDLE, held in REQ while the RAM is driven, and returned for
//   exactly one cycle in RESP (iwait low). RAM errors and timeouts return
//   ERRWORD with ierr. The data port (dbusy) pre-empts any instruction access.
//
// Parameters
//   TIMEOUT  REQ cycles allowed before the access is abandoned as an error
//   ERRWORD  word returned for an errored or timed-out fetch
//
// Ports
//   CLK, RST          clock, synchronous active-high reset
//   iREN, iaddr       instruction read request / word address
//   iwait, iload      response not ready / returned word
//   ierr              one-cycle error flag, coincident with iwait low
//   dbusy             data port owns the RAM
//   ramREN, ramaddr   RAM read enable / address
//   ramload, ramstate RAM read data / status (0 FREE, 1 BUSY, 2 ACCESS, 3 ERROR)
//
// Build option
//   IMEM_LOADBUF_EN   adds a one-entry last-fetch buffer; a repeat request
//                     for the buffered address responds without a RAM access.
//
// state | meaning
// IDLE  | waiting for a request; only state that accepts one
// REQ   | driving the RAM, waiting for ACCESS/ERROR/timeout or an abort
// RESP  | iwait low for one cycle, iload/ierr valid

module imem_responder #(
   parameter int unsigned TIMEOUT = 15,
   parameter logic [31:0] ERRWORD = 32'hBAD1BAD1
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        iREN,
   input  logic [31:0] iaddr,
   output logic        iwait,
   output logic [31:0] iload,
   output logic        ierr,
   input  logic        dbusy,
   output logic        ramREN,
   output logic [31:0] ramaddr,
   input  logic [31:0] ramload,
   input  logic [1:0]  ramstate
);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP} state_e;

   localparam logic [1:0] RAM_ACCESS = 2'd2;
   localparam logic [1:0] RAM_ERROR  = 2'd3;

   state_e      state_q, state_d;
   logic [31:0] addr_q, addr_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [31:0] data_q, data_d;
   logic        err_q, err_d;
   logic        timeout_hit;

`ifdef IMEM_LOADBUF_EN
   logic [31:0] buf_addr_q, buf_addr_d;
   logic [31:0] buf_data_q, buf_data_d;
   logic        buf_valid_q, buf_valid_d;
`endif

   // cnt_q holds the number of REQ cycles already spent, so the current cycle
   // is number cnt_q+1; the fetch is abandoned at the end of cycle TIMEOUT.
   assign timeout_hit = ({28'd0, cnt_q} + 32'd1) >= TIMEOUT;

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      cnt_d   = cnt_q;
      data_d  = data_q;
      err_d   = err_q;
`ifdef IMEM_LOADBUF_EN
      buf_addr_d  = buf_addr_q;
      buf_data_d  = buf_data_q;
      buf_valid_d = buf_valid_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (iREN && !dbusy) begin
               addr_d  = iaddr;
               cnt_d   = 4'd0;
               state_d = S_REQ;
`ifdef IMEM_LOADBUF_EN
               if (buf_valid_q && (iaddr == buf_addr_q)) begin
                  data_d  = buf_data_q;
                  err_d   = 1'b0;
                  state_d = S_RESP;
               end
`endif
            end
         end
         S_REQ: begin
            // Abort wins over a same-cycle ACCESS/ERROR: the requester has
            // already moved on, so the word must not be returned.
            if (!iREN || (iaddr != addr_q) || dbusy) begin
               state_d = S_IDLE;
            end else if (ramstate == RAM_ACCESS) begin
               data_d  = ramload;
               err_d   = 1'b0;
               state_d = S_RESP;
            end else if ((ramstate == RAM_ERROR) || timeout_hit) begin
               data_d  = ERRWORD;
               err_d   = 1'b1;
               state_d = S_RESP;
`ifdef IMEM_LOADBUF_EN
               buf_valid_d = 1'b0;
`endif
            end else if (cnt_q != 4'hF) begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         S_RESP: begin
            state_d = S_IDLE;
            err_d   = 1'b0;
`ifdef IMEM_LOADBUF_EN
            if (!err_q) begin
               buf_addr_d  = addr_q;
               buf_data_d  = data_q;
               buf_valid_d = 1'b1;
            end
`endif
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         cnt_q   <= '0;
         data_q  <= '0;
         err_q   <= 1'b0;
`ifdef IMEM_LOADBUF_EN
         buf_addr_q  <= '0;
         buf_data_q  <= '0;
         buf_valid_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         cnt_q   <= cnt_d;
         data_q  <= data_d;
         err_q   <= err_d;
`ifdef IMEM_LOADBUF_EN
         buf_addr_q  <= buf_addr_d;
         buf_data_q  <= buf_data_d;
         buf_valid_q <= buf_valid_d;
`endif
      end
   end

   assign iwait   = (state_q != S_RESP);
   assign ierr    = (state_q == S_RESP) && err_q;
   assign iload   = data_q;
   assign ramREN  = (state_q == S_REQ);
   assign ramaddr = ramREN ? addr_q : 32'd0;

endmodule
